// File: rtl/fetch_pkg.sv
// Shared constants for the instruction-fetch stage.
package fetch_pkg;

  localparam int          XLEN_DEFAULT     = 32;
  localparam int          INSTR_W          = 32;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous {pc, instr} queue with push/pop/flush and occupancy count.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH = 2,
  parameter int  W     = 64,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);

  logic [W-1:0]  mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          push_s;
  logic          pop_s;

  // Never pop an empty queue, never overwrite a full one unless it drains this cycle.
  always_comb begin
    pop_s  = pop && (count_r != {CW{1'b0}});
    push_s = push && ((count_r != CW'(DEPTH)) || pop_s);
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally as DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1'b1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1'b1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1'b1);
        2'b01:   count_r <= count_r - CW'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; contents are qualified by the count so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_s && !flush) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  assign rdata = mem_r[rd_ptr_r];
  assign count = count_r;
  assign empty = (count_r == {CW{1'b0}});
  assign full  = (count_r == CW'(DEPTH));

endmodule

// File: rtl/fetch_buf.sv
// Instruction-fetch stage: PC, credit-based issue to a 1-cycle imem, and a
// decoupling queue handing {pc, instr} to decode over valid/ready.
module fetch_buf
  import fetch_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter int              DEPTH    = 2,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                redirect_i,
  input  logic [XLEN-1:0]     redirect_pc_i,
  output logic                imem_req_o,
  output logic [XLEN-1:0]     imem_addr_o,
  input  logic [INSTR_W-1:0]  imem_rdata_i,
  output logic                valid_o,
  input  logic                ready_i,
  output logic [INSTR_W-1:0]  instr_o,
  output logic [XLEN-1:0]     pc_o,
  output logic [XLEN-1:0]     pc_plus4_o
);

  localparam int              CW         = $clog2(DEPTH + 1);
  localparam int              CW1        = CW + 1;
  localparam int              W          = XLEN + INSTR_W;
  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(3'd4);
  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  logic [XLEN-1:0] fetch_pc_r;
  logic [XLEN-1:0] inflight_pc_r;
  logic            inflight_r;
  logic            kill_r;

  logic            pop_s;
  logic            push_s;
  logic            fifo_push_s;
  logic            issue_s;
  logic [CW1-1:0]  credit_s;
  logic [W-1:0]    head_s;
  logic [CW-1:0]   count_s;
  logic            empty_s;
  logic            full_s;
  logic [XLEN-1:0] target_s;

  // Handshake, response capture and credit check; a redirect cancels pop, push and issue.
  always_comb begin
    target_s    = redirect_pc_i & ALIGN_MASK;
    pop_s       = !empty_s && ready_i && !redirect_i;
    push_s      = inflight_r && !kill_r && !redirect_i;
    fifo_push_s = push_s && (!full_s || pop_s);
    credit_s    = {1'b0, count_s} + CW1'(inflight_r) - CW1'(pop_s);
    issue_s     = rst_n && !redirect_i && (credit_s < CW1'(DEPTH));
  end

  // PC, in-flight tracking and kill of a response that belongs to the old stream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_r    <= RESET_PC;
      inflight_pc_r <= {XLEN{1'b0}};
      inflight_r    <= 1'b0;
      kill_r        <= 1'b0;
    end else if (redirect_i) begin
      fetch_pc_r    <= target_s;
      inflight_r    <= 1'b0;
      kill_r        <= inflight_r;
    end else begin
      kill_r <= 1'b0;
      if (issue_s) begin
        inflight_pc_r <= fetch_pc_r;
        fetch_pc_r    <= fetch_pc_r + PC_STEP;
        inflight_r    <= 1'b1;
      end else begin
        inflight_r    <= 1'b0;
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .W     (W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push_s),
    .pop   (pop_s),
    .flush (redirect_i),
    .wdata ({inflight_pc_r, imem_rdata_i}),
    .rdata (head_s),
    .count (count_s),
    .empty (empty_s),
    .full  (full_s)
  );

  // Head presentation; an empty queue shows a NOP at PC 0.
  always_comb begin
    imem_req_o  = issue_s;
    imem_addr_o = fetch_pc_r;
    valid_o     = !empty_s;
    if (!empty_s) begin
      instr_o = head_s[INSTR_W-1:0];
      pc_o    = head_s[W-1:INSTR_W];
    end else begin
      instr_o = NOP_INSTR;
      pc_o    = {XLEN{1'b0}};
    end
    pc_plus4_o = pc_o + PC_STEP;
  end

endmodule

// File: tb/tb_fetch_buf.sv
// Directed table-driven bench for fetch_buf (DEPTH=2, RESET_PC=0x100).
module tb_fetch_buf;

  localparam int          XLEN = 32;
  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC  = 32'h0000_0100;
  localparam logic [31:0] KEY  = 32'h5A5A_0000;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = 32'h0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_rdata_i = 32'h0;
  logic        valid_o;
  logic        ready_i = 1'b0;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;

  typedef struct {
    logic        redir;
    logic [31:0] rpc;
    logic        rdy;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] pc;
  } vec_t;

  vec_t tbl [0:32];
  int   total = 0;
  int   bad = 0;

  fetch_buf #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk(clk), .rst_n(rst_n), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_rdata_i(imem_rdata_i),
    .valid_o(valid_o), .ready_i(ready_i), .instr_o(instr_o), .pc_o(pc_o),
    .pc_plus4_o(pc_plus4_o)
  );

  always #5 clk = ~clk;

  // Instruction memory: one-cycle latency, data is a scrambled copy of the address.
  always @(posedge clk) begin
    if (imem_req_o) imem_rdata_i <= imem_addr_o ^ KEY;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input int row, input logic req, input logic [31:0] addr,
                               input logic vld, input logic [31:0] pc);
    logic [31:0] epc;
    epc = vld ? pc : 32'h0;
    check($sformatf("req[%0d]", row), {31'd0, imem_req_o}, {31'd0, req});
    if (req) check($sformatf("addr[%0d]", row), imem_addr_o, addr);
    check($sformatf("valid[%0d]", row), {31'd0, valid_o}, {31'd0, vld});
    check($sformatf("pc[%0d]", row), pc_o, epc);
    check($sformatf("pc4[%0d]", row), pc_plus4_o, epc + 32'd4);
    check($sformatf("instr[%0d]", row), instr_o, vld ? (pc ^ KEY) : NOP);
  endtask

  task automatic set_row(input int i, input logic rd, input logic [31:0] rp, input logic ry,
                         input logic rq, input logic [31:0] ad, input logic v, input logic [31:0] p);
    tbl[i] = '{rd, rp, ry, rq, ad, v, p};
  endtask

  task automatic apply(input int i);
    redirect_i    = tbl[i].redir;
    redirect_pc_i = tbl[i].rpc;
    ready_i       = tbl[i].rdy;
    #1;
    check_outputs(i, tbl[i].req, tbl[i].addr, tbl[i].vld, tbl[i].pc);
    @(negedge clk);
  endtask

  initial begin
    // streaming from reset
    set_row(0,  1'b0, 32'h0, 1'b1, 1'b1, 32'h100, 1'b0, 32'h0);
    set_row(1,  1'b0, 32'h0, 1'b1, 1'b1, 32'h104, 1'b0, 32'h0);
    set_row(2,  1'b0, 32'h0, 1'b1, 1'b1, 32'h108, 1'b1, 32'h100);
    set_row(3,  1'b0, 32'h0, 1'b1, 1'b1, 32'h10C, 1'b1, 32'h104);
    // five-cycle stall: head held, requests stop at the credit limit
    for (int i = 4; i <= 8; i++) set_row(i, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h108);
    set_row(9,  1'b0, 32'h0, 1'b1, 1'b1, 32'h110, 1'b1, 32'h108);
    set_row(10, 1'b0, 32'h0, 1'b1, 1'b1, 32'h114, 1'b1, 32'h10C);
    set_row(11, 1'b0, 32'h0, 1'b1, 1'b1, 32'h118, 1'b1, 32'h110);
    set_row(12, 1'b0, 32'h0, 1'b1, 1'b1, 32'h11C, 1'b1, 32'h114);
    // redirect with a request in flight and credits exhausted
    set_row(13, 1'b1, 32'h2002, 1'b0, 1'b0, 32'h0, 1'b1, 32'h118);
    set_row(14, 1'b0, 32'h0, 1'b1, 1'b1, 32'h2000, 1'b0, 32'h0);
    set_row(15, 1'b0, 32'h0, 1'b1, 1'b1, 32'h2004, 1'b0, 32'h0);
    set_row(16, 1'b0, 32'h0, 1'b1, 1'b1, 32'h2008, 1'b1, 32'h2000);
    set_row(17, 1'b0, 32'h0, 1'b1, 1'b1, 32'h200C, 1'b1, 32'h2004);
    // redirect coinciding with valid & ready
    set_row(18, 1'b1, 32'h3000, 1'b1, 1'b0, 32'h0, 1'b1, 32'h2008);
    set_row(19, 1'b0, 32'h0, 1'b1, 1'b1, 32'h3000, 1'b0, 32'h0);
    set_row(20, 1'b0, 32'h0, 1'b1, 1'b1, 32'h3004, 1'b0, 32'h0);
    set_row(21, 1'b0, 32'h0, 1'b1, 1'b1, 32'h3008, 1'b1, 32'h3000);
    set_row(22, 1'b0, 32'h0, 1'b1, 1'b1, 32'h300C, 1'b1, 32'h3004);
    // PC wrap at the top of the address space
    set_row(23, 1'b1, 32'hFFFF_FFFE, 1'b1, 1'b0, 32'h0, 1'b1, 32'h3008);
    set_row(24, 1'b0, 32'h0, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
    set_row(25, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0, 1'b0, 32'h0);
    set_row(26, 1'b0, 32'h0, 1'b1, 1'b1, 32'h4, 1'b1, 32'hFFFF_FFFC);
    set_row(27, 1'b0, 32'h0, 1'b1, 1'b1, 32'h8, 1'b1, 32'h0);
    set_row(28, 1'b0, 32'h0, 1'b1, 1'b1, 32'hC, 1'b1, 32'h4);
    // restart after a mid-stream reset pulse
    set_row(29, 1'b0, 32'h0, 1'b1, 1'b1, 32'h100, 1'b0, 32'h0);
    set_row(30, 1'b0, 32'h0, 1'b1, 1'b1, 32'h104, 1'b0, 32'h0);
    set_row(31, 1'b0, 32'h0, 1'b1, 1'b1, 32'h108, 1'b1, 32'h100);
    set_row(32, 1'b0, 32'h0, 1'b1, 1'b1, 32'h10C, 1'b1, 32'h104);

    repeat (3) @(negedge clk);
    #1;
    check_outputs(-1, 1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i <= 28; i++) apply(i);

    // mid-stream: one more streaming cycle, then reset dropped between edges
    #1;
    check_outputs(100, 1'b1, 32'h10, 1'b1, 32'h8);
    #1;
    rst_n = 1'b0;
    #1;
    check_outputs(101, 1'b0, 32'h0, 1'b0, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 29; i <= 32; i++) apply(i);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
